// File: rtl/epd_pkg.sv
// Shared constants, state encoding and CRC-32 helpers for the epd frame path.
// Latency: n/a (package only, no logic).
// Backpressure: n/a.
package epd_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;

  localparam int PREAMBLE_LEN = 7;
  localparam int ADDR_LEN     = 6;
  localparam int TYPE_LEN     = 2;
  localparam int FCS_LEN      = 4;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  // Header as shifted out on the line: dst first, MSB first.
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] type_length;
  } hdr_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The engine runs LSB-first, so it works on the bit-reversed polynomial.
  localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/epd_crc32.sv
// Byte-wise reflected CRC-32 accumulator with synchronous clear and enable.
// Latency: crc reflects a byte one cycle after enable; clear wins over enable.
// Backpressure: none; caller gates enable.
module epd_crc32
  import epd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // CRC register: seed on clear, fold in one byte per enabled cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       crc <= CRC32_INIT;
    else if (clear)  crc <= CRC32_INIT;
    else if (enable) crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/epd_frame_tx.sv
// Byte-wide Ethernet framer: preamble/SFD/header/payload/pad/trailer then IFG, feeding epd.
// Latency: start accepted at edge k -> first preamble byte on data at edge k+1; payload byte on data one edge after transfer.
// Backpressure: pay_ready only in PAYLOAD; a missing byte there aborts the frame (underrun). EPD_FRAME_TX_FCS_EN selects CRC-32 trailer.
module epd_frame_tx
  import epd_pkg::*;
#(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] type_length,
  input  logic        pay_valid,
  input  logic [7:0]  pay_data,
  input  logic        pay_last,
  output logic        pay_ready,
  output logic [7:0]  data,
  output logic        control,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic        oversize
);

  localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  ADDR_LAST = 8'(ADDR_LEN - 1);
  localparam logic [7:0]  TYPE_LAST = 8'(TYPE_LEN - 1);
  localparam logic [7:0]  FCS_LAST  = 8'(FCS_LEN - 1);
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_L     = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_L     = 11'(MAX_PAYLOAD);

  state_t      state, state_n;
  logic [7:0]  byte_cnt, byte_cnt_n;
  logic [10:0] pay_cnt, pay_cnt_n, pay_inc;
  hdr_t        hdr_q;
  logic        load_hdr, shift_hdr;
  logic        start_ok, xfer;
  logic [7:0]  data_n, fcs_byte;
  logic        control_n, done_n, underrun_n, oversize_n;

  assign pay_ready = (state == ST_PAYLOAD);
  assign busy      = (state != ST_IDLE);
  assign xfer      = pay_valid & pay_ready;
  assign pay_inc   = (pay_cnt == MAX_L) ? MAX_L : pay_cnt + 11'd1;
  // Start is only looked at when the line is free or about to be (last IFG cycle).
  assign start_ok  = start & ((state == ST_IDLE) | ((state == ST_IFG) & (byte_cnt == IFG_LAST)));

`ifdef EPD_FRAME_TX_FCS_EN
  logic [31:0] crc, fcs_word;
  logic        crc_clr, crc_en;

  assign crc_clr  = start_ok;
  // Cover every byte actually put on the line from DST through PAD.
  assign crc_en   = control_n & (state inside {ST_DST, ST_SRC, ST_TYPE, ST_PAYLOAD, ST_PAD});
  assign fcs_word = ~crc;

  epd_crc32 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .data   (data_n),
    .crc    (crc)
  );

  // Trailer goes out least-significant byte first.
  always_comb begin
    fcs_byte = fcs_word[7:0];
    case (byte_cnt[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end
`else
  assign fcs_byte = IDLE_BYTE;
`endif

  // Next-state and next line byte; outputs are registered one cycle behind the state.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    pay_cnt_n  = pay_cnt;
    load_hdr   = 1'b0;
    shift_hdr  = 1'b0;
    data_n     = IDLE_BYTE;
    control_n  = 1'b0;
    done_n     = 1'b0;
    underrun_n = 1'b0;
    oversize_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_n    = ST_PRE;
          byte_cnt_n = 8'd0;
          load_hdr   = 1'b1;
        end
      end
      ST_PRE: begin
        data_n     = PREAMBLE_BYTE;
        control_n  = 1'b1;
        byte_cnt_n = byte_cnt + 8'd1;
        if (byte_cnt == PRE_LAST) begin
          state_n    = ST_SFD;
          byte_cnt_n = 8'd0;
        end
      end
      ST_SFD: begin
        data_n    = SFD_BYTE;
        control_n = 1'b1;
        state_n   = ST_DST;
      end
      ST_DST, ST_SRC, ST_TYPE: begin
        data_n     = hdr_q[111:104];
        control_n  = 1'b1;
        shift_hdr  = 1'b1;
        byte_cnt_n = byte_cnt + 8'd1;
        if (state == ST_DST && byte_cnt == ADDR_LAST) begin
          state_n    = ST_SRC;
          byte_cnt_n = 8'd0;
        end else if (state == ST_SRC && byte_cnt == ADDR_LAST) begin
          state_n    = ST_TYPE;
          byte_cnt_n = 8'd0;
        end else if (state == ST_TYPE && byte_cnt == TYPE_LAST) begin
          state_n    = ST_PAYLOAD;
          byte_cnt_n = 8'd0;
          pay_cnt_n  = 11'd0;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          data_n    = pay_data;
          control_n = 1'b1;
          pay_cnt_n = pay_inc;
          if (pay_last) begin
            state_n = (pay_inc < MIN_L) ? ST_PAD : ST_FCS;
          end else if (pay_inc == MAX_L) begin
            oversize_n = 1'b1;
            state_n    = ST_FCS;
          end
        end else begin
          // Starved mid-frame: abandon it, no pad or trailer.
          underrun_n = 1'b1;
          state_n    = ST_IFG;
          byte_cnt_n = 8'd0;
        end
      end
      ST_PAD: begin
        data_n    = IDLE_BYTE;
        control_n = 1'b1;
        pay_cnt_n = pay_cnt + 11'd1;
        if (pay_cnt == MIN_L - 11'd1) begin
          state_n    = ST_FCS;
          byte_cnt_n = 8'd0;
        end
      end
      ST_FCS: begin
        data_n     = fcs_byte;
        control_n  = 1'b1;
        byte_cnt_n = byte_cnt + 8'd1;
        if (byte_cnt == FCS_LAST) begin
          done_n     = 1'b1;
          state_n    = ST_IFG;
          byte_cnt_n = 8'd0;
        end
      end
      ST_IFG: begin
        byte_cnt_n = byte_cnt + 8'd1;
        if (byte_cnt == IFG_LAST) begin
          byte_cnt_n = 8'd0;
          if (start_ok) begin
            state_n  = ST_PRE;
            load_hdr = 1'b1;
          end else begin
            state_n  = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      byte_cnt <= 8'd0;
      pay_cnt  <= 11'd0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      pay_cnt  <= pay_cnt_n;
    end
  end

  // Header capture on accepted start, then shifted out a byte at a time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          hdr_q <= '0;
    else if (load_hdr)  hdr_q <= hdr_t'{dst: dst_addr, src: src_addr, type_length: type_length};
    else if (shift_hdr) hdr_q <= {hdr_q[103:0], IDLE_BYTE};
  end

  // Registered line outputs and status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data       <= IDLE_BYTE;
      control    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      oversize   <= 1'b0;
    end else begin
      data       <= data_n;
      control    <= control_n;
      frame_done <= done_n;
      underrun   <= underrun_n;
      oversize   <= oversize_n;
    end
  end

endmodule

// File: doc/epd_frame_tx.md
Name: epd_frame_tx

Overview:
Byte-wide Ethernet frame transmitter that sits directly upstream of epd and drives its data/control inputs. It takes header fields on a start pulse and payload through a valid/ready stream. It emits preamble, SFD, DST, SRC, type/length, payload, zero pad and a 4-byte trailer, then inserts a programmable inter-frame gap (IFG). Its outputs connect straight to epd's data and control ports.

Parameters:
IFG_BYTES, 12, number of control=0 cycles after each frame (legal 1..255)
MIN_PAYLOAD, 46, payload+pad minimum byte count
MAX_PAYLOAD, 1500, payload byte count at which the frame is force-terminated

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high
start  input  1  frame request; sampled only in IDLE or the last IFG cycle
dst_addr  input  48  destination address, latched on accepted start
src_addr  input  48  source address, latched on accepted start
type_length  input  16  type/length field, latched on accepted start
pay_valid  input  1  payload byte valid
pay_data  input  8  payload byte
pay_last  input  1  marks final payload byte
pay_ready  output  1  block accepts a payload byte this cycle
data  output  8  line byte (to epd data)
control  output  1  1 = frame byte, 0 = idle/IFG (to epd control)
busy  output  1  high from accepted start through the last IFG cycle
frame_done  output  1  one-cycle pulse, coincident with the last trailer byte on data
underrun  output  1  one-cycle pulse on payload starvation
oversize  output  1  one-cycle pulse on MAX_PAYLOAD truncation

Behaviour:
- Reset is asynchronous and active-high. Reset values: data=8'h00, control=0, pay_ready=0, busy=0, frame_done=0, underrun=0, oversize=0, state=IDLE, header registers=0.
- data and control are registered. A start accepted at edge k gives the first 0x55 at edge k+1.
- States and byte counts: IDLE, PRE (7 x 8'h55), SFD (8'hD5), DST (6), SRC (6), TYPE (2), PAYLOAD, PAD, FCS (4), IFG (IFG_BYTES).
- Field order is most-significant byte first: dst_addr[47:40] first, type_length[15:8] first.
- control=1 in PRE through FCS. control=0 with data=8'h00 in IDLE and IFG.
- pay_ready is high exactly in PAYLOAD cycles. A transfer occurs on pay_valid & pay_ready, and the byte appears on data the next cycle.
- Payload counter is 11 bits and saturates at MAX_PAYLOAD.
- PAYLOAD exit rules:
  - pay_last transferred with count < MIN_PAYLOAD: go to PAD, emitting 8'h00 until payload+pad = MIN_PAYLOAD.
  - Otherwise pay_last transferred: go to FCS.
- Underrun: pay_valid=0 during PAYLOAD pulses underrun, and control goes low on the next edge. The block goes to IFG, drives no pad or FCS, and never pulses frame_done.
- Oversize: byte number MAX_PAYLOAD transferred without pay_last pulses oversize and is treated as last. The block goes to FCS, and pay_ready stays low until the next frame. Upstream discards the remainder of the payload.
- FCS emits 4 bytes, then IFG for exactly IFG_BYTES cycles, then IDLE.
- Back-to-back frames: start high during the last IFG cycle is accepted. The gap is then exactly IFG_BYTES.
- start outside IDLE or the last IFG cycle is ignored, and header inputs are not re-latched.
- A 46-byte payload frame is 72 control-high cycles.
- Reset mid-frame: the line drops to control=0, data=0 immediately (asynchronous). No partial trailer is emitted, and the block idles until a new start.

Optional Feature:
Macro: EPD_FRAME_TX_FCS_EN.
- Defined: the trailer is IEEE 802.3 CRC-32 over DST..PAD.
  - Polynomial 32'h04C11DB7, initial value 32'hFFFFFFFF, reflected, final complement.
  - Transmitted least-significant byte first.
- Undefined: the trailer is 4 x 8'h00 and no CRC logic is instantiated. Frame length and timing are identical in both builds.

Decomposition:
- Shared package epd_pkg:
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, IDLE_BYTE 8'h00
  - PREAMBLE_LEN 7, ADDR_LEN 6, TYPE_LEN 2, FCS_LEN 4
  - State encoding
  - CRC32_POLY and CRC32_RESIDUE 32'hC704DD7B
- Sub-module epd_crc32: byte-wise CRC engine with clear/enable, instantiated only under EPD_FRAME_TX_FCS_EN.

Test Plan:
1. Minimum frame: dst 01..06, src FF..FA, type 0x0800, 46 x 8'h55 with pay_valid held high. Required response:
   - 72 control=1 cycles in order 7x55, D5, 01..06, FF..FA, 08, 00, payload, 4 trailer bytes.
   - frame_done pulses on the last trailer byte.
   - A downstream epd asserts all valids and valid_packet_counter=1.
2. Short payload: 10 bytes. Required: 36 bytes of 8'h00 pad, total still 72 control=1 cycles.
3. Back-to-back: IFG_BYTES=1, start held high, three frames. Required: exactly one control=0 cycle between frames, and epd counter reaches 3.
4. Underrun: pay_valid dropped at payload byte 20. Required: underrun pulses once, control=0 on the next edge, no frame_done, and the next start produces a clean frame.
5. Reset asserted mid-PAYLOAD. Required: data=0, control=0, pay_ready=0 immediately; busy=0; a later start produces a full 72-byte frame.
6. With EPD_FRAME_TX_FCS_EN: run scenario 1. Required: the CRC-32 recomputed over DST..FCS equals residue 32'hC704DD7B. Without the macro, the trailer is 00 00 00 00.
